// File: rtl/cpu_seq_pkg.sv
// Shared definitions for the CPU stage sequencer: state encoding, stage strobe
// indices and the default instruction-register reset value.
package cpu_seq_pkg;

    typedef enum logic [2:0] {
        ST_RST,
        ST_FETCH,
        ST_GETREGS,
        ST_READMEM,
        ST_WRITEBACK,
        ST_HOLD
    } seq_state_e;

    localparam int unsigned STG_FETCH     = 0;
    localparam int unsigned STG_GETREGS   = 1;
    localparam int unsigned STG_READMEM   = 2;
    localparam int unsigned STG_WRITEBACK = 3;
    localparam int unsigned STG_NUM       = 4;

    localparam logic [31:0] INSTR_RESET_DEFAULT = 32'h0000_0000;

    // One-hot strobe pattern for a state; RST and HOLD drive no strobe.
    function automatic logic [STG_NUM-1:0] stage_strobes(input seq_state_e st);
        logic [STG_NUM-1:0] s;
        s = '0;
        case (st)
            ST_FETCH:     s[STG_FETCH]     = 1'b1;
            ST_GETREGS:   s[STG_GETREGS]   = 1'b1;
            ST_READMEM:   s[STG_READMEM]   = 1'b1;
            ST_WRITEBACK: s[STG_WRITEBACK] = 1'b1;
            default:      s = '0;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/seq_wait_timer.sv
// Memory-stage wait counter: counts wait cycles, saturates at all-ones and
// flags expiry when TIMEOUT wait cycles have elapsed with busy still high.
module seq_wait_timer #(
    parameter int unsigned TIMEOUT = 0,
    parameter int unsigned TO_W    = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic waiting,
    input  logic advance,
    input  logic busy,
    output logic expire
);

    // cnt_q holds the number of completed wait cycles, so the TIMEOUT-th wait
    // cycle is the one that sees cnt_q == TIMEOUT-1.
    localparam logic [TO_W-1:0] LIMIT = (TIMEOUT == 0) ? '0 : TO_W'(TIMEOUT - 1);

    logic [TO_W-1:0] cnt_q;
    logic [TO_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (!waiting || advance) begin
            cnt_d = '0;
        end else if (cnt_q != '1) begin
            cnt_d = cnt_q + 1'b1;
        end
        expire = (TIMEOUT != 0) && waiting && busy && (cnt_q == LIMIT);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/cpu_stage_sequencer.sv
// CPU stage sequencer: registered one-hot stage strobes, memory busy stretch,
// instruction latch, PC advance pulse and debug hold. Define SEQ_PERF_CNT_EN
// to add the cycle_cnt / instr_cnt performance counters.
module cpu_stage_sequencer
    import cpu_seq_pkg::*;
#(
    parameter logic [31:0] INSTR_RESET = INSTR_RESET_DEFAULT,
    parameter int unsigned TIMEOUT     = 0,
    parameter int unsigned TO_W        = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mem_start,
    input  logic        busy,
    input  logic [31:0] q,
    input  logic        hold,
    output logic        fetch,
    output logic        getRegs,
    output logic        readMem,
    output logic        writeBack,
    output logic [31:0] instr,
    output logic        pc_next,
    output logic        halted,
    output logic        mem_timeout
`ifdef SEQ_PERF_CNT_EN
    ,
    output logic [31:0] cycle_cnt,
    output logic [31:0] instr_cnt
`endif
);

    seq_state_e         state_q, state_d;
    logic               wait_q, wait_d;
    logic [STG_NUM-1:0] strobe_q, strobe_d;
    logic [31:0]        instr_q, instr_d;
    logic               pc_next_q, pc_next_d;
    logic               halted_q, halted_d;
    logic               mem_timeout_q, mem_timeout_d;
    logic               advance;
    logic               expire;

    seq_wait_timer #(
        .TIMEOUT (TIMEOUT),
        .TO_W    (TO_W)
    ) u_wait_timer (
        .clk     (clk),
        .reset   (reset),
        .waiting (wait_q),
        .advance (advance),
        .busy    (busy),
        .expire  (expire)
    );

    always_comb begin
        state_d       = state_q;
        wait_d        = wait_q;
        instr_d       = instr_q;
        pc_next_d     = 1'b0;
        mem_timeout_d = mem_timeout_q;
        advance       = 1'b0;

        case (state_q)
            ST_RST:  state_d = ST_FETCH;
            ST_HOLD: if (!hold) state_d = ST_FETCH;
            default: begin
                // Issue cycle decides memory use; busy only counts once waiting.
                if (!wait_q) begin
                    if (mem_start) wait_d = 1'b1;
                    else           advance = 1'b1;
                end else if (!busy || expire) begin
                    advance = 1'b1;
                    if (busy) mem_timeout_d = 1'b1;
                end
            end
        endcase

        if (advance) begin
            wait_d = 1'b0;
            case (state_q)
                ST_FETCH: begin
                    instr_d = q;
                    state_d = ST_GETREGS;
                end
                ST_GETREGS: state_d = ST_READMEM;
                ST_READMEM: state_d = ST_WRITEBACK;
                default: begin
                    pc_next_d = 1'b1;
                    state_d   = hold ? ST_HOLD : ST_FETCH;
                end
            endcase
        end

        strobe_d = stage_strobes(state_d);
        halted_d = (state_d == ST_HOLD);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_RST;
            wait_q        <= 1'b0;
            strobe_q      <= '0;
            instr_q       <= INSTR_RESET;
            pc_next_q     <= 1'b0;
            halted_q      <= 1'b0;
            mem_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            wait_q        <= wait_d;
            strobe_q      <= strobe_d;
            instr_q       <= instr_d;
            pc_next_q     <= pc_next_d;
            halted_q      <= halted_d;
            mem_timeout_q <= mem_timeout_d;
        end
    end

    assign fetch       = strobe_q[STG_FETCH];
    assign getRegs     = strobe_q[STG_GETREGS];
    assign readMem     = strobe_q[STG_READMEM];
    assign writeBack   = strobe_q[STG_WRITEBACK];
    assign instr       = instr_q;
    assign pc_next     = pc_next_q;
    assign halted      = halted_q;
    assign mem_timeout = mem_timeout_q;

`ifdef SEQ_PERF_CNT_EN
    logic [31:0] cycle_cnt_q, cycle_cnt_d;
    logic [31:0] instr_cnt_q, instr_cnt_d;

    always_comb begin
        cycle_cnt_d = cycle_cnt_q + 32'd1;
        instr_cnt_d = instr_cnt_q + {31'b0, pc_next_d};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cycle_cnt_q <= '0;
            instr_cnt_q <= '0;
        end else begin
            cycle_cnt_q <= cycle_cnt_d;
            instr_cnt_q <= instr_cnt_d;
        end
    end

    assign cycle_cnt = cycle_cnt_q;
    assign instr_cnt = instr_cnt_q;
`endif

endmodule

// File: tb/tb_cpu_stage_sequencer.sv
// Scoreboard bench for cpu_stage_sequencer (TIMEOUT=4): each driven cycle
// queues the outputs expected after the next clock edge.
module tb_cpu_stage_sequencer;

    localparam logic [31:0] IR  = 32'h1357_9BDF;
    localparam logic [3:0]  N   = 4'b0000;
    localparam logic [3:0]  F   = 4'b0001;
    localparam logic [3:0]  G   = 4'b0010;
    localparam logic [3:0]  R   = 4'b0100;
    localparam logic [3:0]  W   = 4'b1000;

    logic        clk;
    logic        reset;
    logic        mem_start;
    logic        busy;
    logic [31:0] q;
    logic        hold;
    logic        fetch;
    logic        getRegs;
    logic        readMem;
    logic        writeBack;
    logic [31:0] instr;
    logic        pc_next;
    logic        halted;
    logic        mem_timeout;
`ifdef SEQ_PERF_CNT_EN
    logic [31:0] cycle_cnt;
    logic [31:0] instr_cnt;
`endif

    typedef struct {
        logic [3:0]  s;
        logic        p;
        logic        h;
        logic        t;
        logic [31:0] i;
        int unsigned c;
        int unsigned n;
    } exp_t;

    exp_t        sb[$];
    int unsigned checks = 0;
    int unsigned errors = 0;
    int unsigned n_cyc  = 0;
    int unsigned n_ins  = 0;
    int unsigned seq    = 0;
    logic [31:0] cur;
    logic [31:0] qv;
    int unsigned k;

    cpu_stage_sequencer #(
        .INSTR_RESET (IR),
        .TIMEOUT     (4),
        .TO_W        (16)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .mem_start   (mem_start),
        .busy        (busy),
        .q           (q),
        .hold        (hold),
        .fetch       (fetch),
        .getRegs     (getRegs),
        .readMem     (readMem),
        .writeBack   (writeBack),
        .instr       (instr),
        .pc_next     (pc_next),
        .halted      (halted),
        .mem_timeout (mem_timeout)
`ifdef SEQ_PERF_CNT_EN
        ,
        .cycle_cnt   (cycle_cnt),
        .instr_cnt   (instr_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic drv(input logic r, input logic ms, input logic b, input logic h,
                       input logic [31:0] qd, input logic [3:0] s, input logic p,
                       input logic hl, input logic to, input logic [31:0] iv);
        exp_t e;
        @(negedge clk);
        reset     = r;
        mem_start = ms;
        busy      = b;
        hold      = h;
        q         = qd;
        if (r) begin
            n_cyc = 0;
            n_ins = 0;
        end else begin
            n_cyc++;
            if (p) n_ins++;
        end
        e = '{s, p, hl, to, iv, n_cyc, n_ins};
        sb.push_back(e);
    endtask

    always @(posedge clk) begin
        exp_t e;
        #1;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            seq++;
            chk($sformatf("strobes@%0d", seq), {28'b0, writeBack, readMem, getRegs, fetch}, {28'b0, e.s});
            chk($sformatf("pc_next@%0d", seq), {31'b0, pc_next}, {31'b0, e.p});
            chk($sformatf("halted@%0d", seq), {31'b0, halted}, {31'b0, e.h});
            chk($sformatf("mem_timeout@%0d", seq), {31'b0, mem_timeout}, {31'b0, e.t});
            chk($sformatf("instr@%0d", seq), instr, e.i);
`ifdef SEQ_PERF_CNT_EN
            chk($sformatf("cycle_cnt@%0d", seq), cycle_cnt, e.c);
            chk($sformatf("instr_cnt@%0d", seq), instr_cnt, e.n);
`endif
        end
    end

    initial begin
        reset = 1'b1; mem_start = 1'b0; busy = 1'b0; hold = 1'b0; q = '0;
        cur = IR;

        drv(1, 0, 0, 0, 32'h0, N, 0, 0, 0, IR);
        drv(1, 1, 1, 1, 32'h0, N, 0, 0, 0, IR);

        // Basic instruction: memory fetch, busy low on first wait cycle
        drv(0, 0, 0, 0, 32'h0,         F, 0, 0, 0, IR);
        drv(0, 1, 1, 0, 32'hAAAA_0001, F, 0, 0, 0, IR);
        drv(0, 0, 0, 0, 32'h1111_2222, G, 0, 0, 0, 32'h1111_2222);
        cur = 32'h1111_2222;
        drv(0, 0, 0, 0, 32'h0, R, 0, 0, 0, cur);
        drv(0, 0, 0, 0, 32'h0, W, 0, 0, 0, cur);
        drv(0, 0, 0, 0, 32'h0, F, 1, 0, 0, cur);

        // Fetch stretched by three busy wait cycles
        drv(0, 1, 0, 0, 32'hDEAD_BEEF, F, 0, 0, 0, cur);
        drv(0, 0, 1, 0, 32'hDEAD_BEEF, F, 0, 0, 0, cur);
        drv(0, 0, 1, 0, 32'hDEAD_BEEF, F, 0, 0, 0, cur);
        drv(0, 0, 1, 0, 32'hDEAD_BEEF, F, 0, 0, 0, cur);
        drv(0, 0, 0, 0, 32'hDEAD_BEEF, G, 0, 0, 0, 32'hDEAD_BEEF);
        cur = 32'hDEAD_BEEF;
        drv(0, 0, 1, 0, 32'h0, R, 0, 0, 0, cur);
        drv(0, 0, 0, 0, 32'h0, W, 0, 0, 0, cur);

        // Debug hold taken at the instruction boundary
        drv(0, 0, 0, 1, 32'h0, N, 1, 1, 0, cur);
        drv(0, 0, 0, 1, 32'h0, N, 0, 1, 0, cur);
        drv(0, 0, 0, 1, 32'h0, N, 0, 1, 0, cur);
        drv(0, 0, 0, 0, 32'h0, F, 0, 0, 0, cur);
        drv(0, 0, 0, 1, 32'hCAFE_0001, G, 0, 0, 0, 32'hCAFE_0001);
        cur = 32'hCAFE_0001;
        drv(0, 0, 0, 1, 32'h0, R, 0, 0, 0, cur);

        // Read stage stuck busy: forced advance after 4 wait cycles
        drv(0, 1, 1, 0, 32'h0, R, 0, 0, 0, cur);
        drv(0, 0, 1, 0, 32'h0, R, 0, 0, 0, cur);
        drv(0, 0, 1, 0, 32'h0, R, 0, 0, 0, cur);
        drv(0, 0, 1, 0, 32'h0, R, 0, 0, 0, cur);
        drv(0, 0, 1, 0, 32'h0, W, 0, 0, 1, cur);
        drv(0, 0, 0, 0, 32'h0, F, 1, 0, 1, cur);
        drv(0, 0, 0, 0, 32'h0BAD_F00D, G, 0, 0, 1, 32'h0BAD_F00D);
        cur = 32'h0BAD_F00D;
        drv(0, 0, 0, 0, 32'h0, R, 0, 0, 1, cur);

        // Reset in the middle of a read wait, then restart
        drv(0, 1, 1, 0, 32'h0, R, 0, 0, 1, cur);
        drv(0, 0, 1, 0, 32'h0, R, 0, 0, 1, cur);
        drv(1, 1, 1, 0, 32'h0, N, 0, 0, 0, IR);
        cur = IR;
        drv(0, 0, 0, 0, 32'h0, F, 0, 0, 0, IR);
        drv(0, 0, 0, 0, 32'h1234_5678, G, 0, 0, 0, 32'h1234_5678);
        drv(0, 0, 0, 0, 32'h0, R, 0, 0, 0, 32'h1234_5678);
        drv(0, 0, 0, 0, 32'h0, W, 0, 0, 0, 32'h1234_5678);
        // Reset and hold together: reset wins
        drv(1, 0, 0, 1, 32'h0, N, 0, 0, 0, IR);
        drv(0, 0, 0, 1, 32'h0, F, 0, 0, 0, IR);

        // Random fetch wait lengths (all well under the timeout)
        for (int n = 0; n < 6; n++) begin
            k  = $urandom_range(0, 2);
            qv = $urandom;
            drv(0, 1, 1, 0, qv, F, 0, 0, 0, cur);
            for (int j = 0; j < int'(k); j++) drv(0, 0, 1, 0, qv, F, 0, 0, 0, cur);
            drv(0, 0, 0, 0, qv, G, 0, 0, 0, qv);
            cur = qv;
            drv(0, 0, 0, 0, 32'h0, R, 0, 0, 0, cur);
            drv(0, 0, 0, 0, 32'h0, W, 0, 0, 0, cur);
            drv(0, 0, 0, 0, 32'h0, F, 1, 0, 0, cur);
        end

        repeat (3) @(posedge clk);
        #2;
        chk("scoreboard_drain", sb.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
